// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master round-robin data bus arbiter with ownership lock.
// Define ARB_TIMEOUT_EN to bound locked ownership to LOCK_MAX transfers.
module dbus_arbiter #(
   parameter int LOCK_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_we,
   output logic        m0_gnt,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_we,
   output logic        m1_gnt,
   output logic [31:0] m1_rdata,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_we,
   input  logic [31:0] s_rdata,
   output logic        busy,
   output logic        owner
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0] state;
   logic [1:0] nxt;
   logic       armed;
   logic       own_q;
   logic       xfer0;
   logic       xfer1;
   logic       keep0;
   logic       keep1;

   if (LOCK_MAX < 2 || LOCK_MAX > 255) begin : g_lock_max_chk
      $error("dbus_arbiter: LOCK_MAX must be 2..255");
   end

   assign m0_gnt = (state == OWN0);
   assign m1_gnt = (state == OWN1);
   assign xfer0  = m0_gnt & m0_req;
   assign xfer1  = m1_gnt & m1_req;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt;
   logic       at_max;

   assign at_max = (cnt == 8'(LOCK_MAX - 1));
   assign keep0  = m0_req & m0_lock & ~(at_max & m1_req);
   assign keep1  = m1_req & m1_lock & ~(at_max & m0_req);

   // Run length of locked transfers by the current owner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 8'd0;
      end else if (nxt != state) begin
         cnt <= 8'd0;
      end else if ((xfer0 & m0_lock) | (xfer1 & m1_lock)) begin
         if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      end else if (xfer0 | xfer1) begin
         cnt <= 8'd0;
      end
   end
`else
   assign keep0 = m0_req & m0_lock;
   assign keep1 = m1_req & m1_lock;
`endif

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (!armed)               nxt = IDLE;
            else if (m0_req && m1_req) nxt = own_q ? OWN0 : OWN1;
            else if (m0_req)          nxt = OWN0;
            else if (m1_req)          nxt = OWN1;
         end
         OWN0: begin
            if (keep0)       nxt = OWN0;
            else if (m1_req) nxt = OWN1;
            else if (m0_req) nxt = OWN0;
            else             nxt = IDLE;
         end
         OWN1: begin
            if (keep1)       nxt = OWN1;
            else if (m0_req) nxt = OWN0;
            else if (m1_req) nxt = OWN1;
            else             nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // armed holds off the first grant until the second edge after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         armed <= 1'b0;
         own_q <= 1'b1;
      end else begin
         state <= nxt;
         armed <= 1'b1;
         if (nxt == OWN0)      own_q <= 1'b0;
         else if (nxt == OWN1) own_q <= 1'b1;
      end
   end

   assign s_addr  = ({32{xfer0}} & m0_addr)  | ({32{xfer1}} & m1_addr);
   assign s_wdata = ({32{xfer0}} & m0_wdata) | ({32{xfer1}} & m1_wdata);
   assign s_we    = ({4{xfer0}} & m0_we)     | ({4{xfer1}} & m1_we);

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign busy     = (state != IDLE);
   assign owner    = own_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: table vectors, directed corner sequences and a
// randomized run against a rule-level model of the arbiter.
module tb_dbus_arbiter;

   localparam int LM = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] A1 = 32'h0000_0200;
   localparam logic [31:0] D0 = 32'h1111_1111;
   localparam logic [31:0] D1 = 32'h2222_2222;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_gnt, m1_gnt;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_we;
   logic        busy, owner;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dbus_arbiter #(.LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_gnt(m0_gnt),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_gnt(m1_gnt),
      .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
      .s_rdata(s_rdata), .busy(busy), .owner(owner)
   );

   // x: 0 no transfer, 1 master 0 transfers, 2 master 1 transfers
   typedef struct {
      logic r0, l0, r1, l1;
      logic g0, g1;
      int   x;
      logic own, bsy;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string nm, input logic [159:0] got,
                        input logic [159:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m0_req = 0; m0_lock = 0; m1_req = 0; m1_lock = 0;
      m0_addr = 0; m0_wdata = 0; m0_we = 0;
      m1_addr = 0; m1_wdata = 0; m1_we = 0;
      s_rdata = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // reference model state
   int who, last, run, nx, o, k, n1;
   bit armed, keep, seen0;
   logic       rq [2];
   logic       lk [2];
   logic [3:0] we [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [3:0]  xwe;
   logic [31:0] xa, xd, rd;
   logic        xf;

   task automatic model_step();
      if (who < 0) begin
         if (!armed)              nx = -1;
         else if (rq[0] && rq[1]) nx = 1 - last;
         else if (rq[0])          nx = 0;
         else if (rq[1])          nx = 1;
         else                     nx = -1;
      end else begin
         o = 1 - who;
         keep = rq[who] && lk[who];
         if (TMO && keep && run == LM - 1 && rq[o]) keep = 0;
         if (keep)         nx = who;
         else if (rq[o])   nx = o;
         else if (rq[who]) nx = who;
         else              nx = -1;
      end
      if (nx != who) run = 0;
      else if (who >= 0 && rq[who])
         run = lk[who] ? (run < 255 ? run + 1 : run) : 0;
      armed = 1;
      if (nx >= 0) last = nx;
      who = nx;
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0, 0,0,0, 1,0};
      tbl[1]  = '{1,0,0,0, 0,0,0, 1,0};
      tbl[2]  = '{1,0,0,0, 1,0,1, 0,1};
      tbl[3]  = '{1,0,1,0, 1,0,1, 0,1};
      tbl[4]  = '{1,0,1,0, 0,1,2, 1,1};
      tbl[5]  = '{1,0,1,0, 1,0,1, 0,1};
      tbl[6]  = '{1,0,0,0, 0,1,0, 1,1};
      tbl[7]  = '{1,1,1,0, 1,0,1, 0,1};
      tbl[8]  = '{1,1,1,0, 1,0,1, 0,1};
      tbl[9]  = '{0,1,0,0, 1,0,0, 0,1};
      tbl[10] = '{0,0,0,0, 0,0,0, 0,0};
      tbl[11] = '{0,0,1,0, 0,0,0, 0,0};
      tbl[12] = '{1,0,1,0, 0,1,2, 1,1};
      tbl[13] = '{0,0,0,0, 1,0,0, 0,1};
      tbl[14] = '{1,0,1,0, 0,0,0, 0,0};
      tbl[15] = '{1,0,1,0, 0,1,2, 1,1};

      // table vectors
      do_reset();
      for (int i = 0; i < 16; i++) begin
         m0_req = tbl[i].r0; m0_lock = tbl[i].l0;
         m1_req = tbl[i].r1; m1_lock = tbl[i].l1;
         m0_addr = A0; m0_wdata = D0; m0_we = 4'hF;
         m1_addr = A1; m1_wdata = D1; m1_we = 4'h3;
         s_rdata = 32'hDEAD_BEEF;
         xwe = 4'h0; xa = 32'h0; xd = 32'h0;
         if (tbl[i].x == 1) begin xwe = 4'hF; xa = A0; xd = D0; end
         if (tbl[i].x == 2) begin xwe = 4'h3; xa = A1; xd = D1; end
         @(negedge clk);
         check($sformatf("vec%0d", i),
               160'({m0_gnt, m1_gnt, s_we, s_addr, s_wdata, owner, busy}),
               160'({tbl[i].g0, tbl[i].g1, xwe, xa, xd, tbl[i].own,
                     tbl[i].bsy}));
         @(posedge clk); #1;
      end

      // grant latency after reset, read data, async reset abort
      do_reset();
      m0_req = 1; m0_addr = 32'h300; m0_we = 4'h0;
      s_rdata = 32'hDEAD_BEEF;
      for (k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (m0_gnt) break;
      end
      check("grant_latency", 160'(k), 160'(3));
      check("read_m0", 160'({m0_rdata, s_addr, s_we}),
            160'({32'hDEAD_BEEF, 32'h300, 4'h0}));
      @(posedge clk); #1 m0_we = 4'hF;
      @(negedge clk);
      check("write_m0", 160'({m0_gnt, s_we}), 160'({1'b1, 4'hF}));
      #2 reset = 1'b0;
      #1;
      check("async_reset",
            160'({m0_gnt, m1_gnt, s_we, busy, owner}),
            160'({1'b0, 1'b0, 4'h0, 1'b0, 1'b1}));

      // locked m1 against a waiting m0
      do_reset();
      m1_req = 1; m1_lock = 1; m1_we = 4'h3; m1_addr = A1;
      m0_we = 4'hF; m0_addr = A0;
      for (k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (m1_gnt) break;
      end
      check("wait_gnt1", 160'(k), 160'(3));
      m0_req = 1;
      n1 = 0; seen0 = 0;
      for (int c = 0; c < 40; c++) begin
         if (!seen0) begin
            if (m0_gnt) seen0 = 1;
            else if (m1_gnt && m1_req) begin
               n1++;
               if (s_we !== 4'h3) begin
                  total++; bad++;
                  $display("FAIL lock_swe got=%h want=3", s_we);
               end
            end
         end
         @(negedge clk);
      end
      check("lock_m1_count", 160'(n1), 160'(TMO ? LM : 40));
      check("lock_switch", 160'(seen0), 160'(TMO));

      // randomized run against the model
      do_reset();
      who = -1; last = 1; run = 0; armed = 0;
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < 2; m++) begin
            rq[m] = ($urandom_range(3) != 0);
            lk[m] = ($urandom_range(3) != 0);
            we[m] = 4'($urandom);
            ad[m] = $urandom;
            wd[m] = $urandom;
         end
         rd = $urandom;
         m0_req = rq[0]; m0_lock = lk[0]; m0_we = we[0];
         m0_addr = ad[0]; m0_wdata = wd[0];
         m1_req = rq[1]; m1_lock = lk[1]; m1_we = we[1];
         m1_addr = ad[1]; m1_wdata = wd[1];
         s_rdata = rd;
         @(negedge clk);
         xf = (who >= 0) && rq[who];
         xwe = xf ? we[who] : 4'h0;
         xa  = xf ? ad[who] : 32'h0;
         xd  = xf ? wd[who] : 32'h0;
         check($sformatf("rand%0d", c),
               160'({m0_gnt, m1_gnt, s_we, s_addr, s_wdata, owner, busy,
                     m0_rdata, m1_rdata}),
               160'({who == 0, who == 1, xwe, xa, xd, last[0], who >= 0,
                     rd, rd}));
         model_step();
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
